correction_sequencer: RTL and testbench

Closed-loop error-correction controller that watches the `error_state` lines of up to `N_CHAN` noise channels and services them one at a time. For each channel it models decode latency, drives a one-cycle `apply_correction` pulse back to the channel, and checks that the error cleared. It then reports the outcome to the host over a valid/ready event port. It sits between the physics-layer noise channels and the QCU host/decoder status path.

---
 rtl/qcu_corr_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/correction_sequencer.sv | 120 ++++++++++++
 tb/tb_correction_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qcu_corr_pkg.sv
// rtl/qcu_corr_pkg.sv - shared types for the correction sequencer
package qcu_corr_pkg;

    localparam int CHAN_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        APPLY,
        VERIFY,
        REPORT
    } corr_state_e;

    // Wide enough for the largest supported channel count (16)
    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic              ok;
    } corr_evt_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting after last
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx
);

    logic [W-1:0] idx;

    // Scan from farthest to nearest so the nearest requester after last wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int i = N; i >= 1; i--) begin
            idx = W'((int'(last) + i) % N);
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/correction_sequencer.sv
// rtl/correction_sequencer.sv - services channel errors one at a time and reports outcomes
module correction_sequencer
    import qcu_corr_pkg::*;
#(
    parameter int N_CHAN         = 4,
    parameter int DECODE_LAT     = 3,
    parameter int VERIFY_TIMEOUT = 4,
    parameter int CNT_W          = 16,
    parameter int CW             = $clog2(N_CHAN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_CHAN-1:0] error_state_i,
    output logic [N_CHAN-1:0] apply_correction_o,
    output logic              busy_o,
    output logic [CW-1:0]     active_chan_o,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [CW-1:0]     evt_chan_o,
    output logic              evt_ok_o,
    output logic [CNT_W-1:0]  corr_count_o,
    output logic [CNT_W-1:0]  fail_count_o
);

    localparam int TMAX = (DECODE_LAT > VERIFY_TIMEOUT) ? DECODE_LAT : VERIFY_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    corr_state_e       state;
    corr_evt_t         evt_q;
    logic [TW-1:0]     timer;
    logic [CW-1:0]     last_chan;
    logic [CW-1:0]     active;
    logic [N_CHAN-1:0] apply_q;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  fail_cnt;
    logic              grant_valid;
    logic [CW-1:0]     grant_idx;

    assign active = CW'(evt_q.chan);

    rr_arbiter #(
        .N (N_CHAN),
        .W (CW)
    ) u_arb (
        .req         (error_state_i),
        .last        (last_chan),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            evt_q     <= '0;
            timer     <= '0;
            last_chan <= CW'(N_CHAN - 1);
            apply_q   <= '0;
            corr_cnt  <= '0;
            fail_cnt  <= '0;
        end else begin
            apply_q <= '0;
            case (state)
                IDLE: begin
                    if (enable && grant_valid) begin
                        evt_q.chan <= CHAN_W'(grant_idx);
                        timer      <= TW'(DECODE_LAT - 1);
                        state      <= DECODE;
                    end
                end
                DECODE: begin
                    // Pulse is registered so it is high exactly while in APPLY
                    if (timer == '0) begin
                        apply_q <= N_CHAN'(1) << active;
                        state   <= APPLY;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                APPLY: begin
                    timer <= TW'(VERIFY_TIMEOUT - 1);
                    state <= VERIFY;
                end
                VERIFY: begin
                    if (!error_state_i[active]) begin
                        evt_q.ok <= 1'b1;
                        state    <= REPORT;
                    end else if (timer == '0) begin
                        evt_q.ok <= 1'b0;
                        state    <= REPORT;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                REPORT: begin
                    if (evt_ready_i) begin
                        if (evt_q.ok) begin
                            if (corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
                        end else begin
                            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                        end
                        last_chan <= active;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign apply_correction_o = apply_q;
    assign busy_o             = (state != IDLE);
    assign active_chan_o      = active;
    assign evt_valid_o        = (state == REPORT);
    assign evt_chan_o         = active;
    assign evt_ok_o           = evt_q.ok;
    assign corr_count_o       = corr_cnt;
    assign fail_count_o       = fail_cnt;

endmodule

// File: tb/tb_correction_sequencer.sv
// tb/tb_correction_sequencer.sv - directed self-checking bench for correction_sequencer
module tb_correction_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] error_state;
    logic [3:0] apply_correction;
    logic       busy;
    logic [1:0] active_chan;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_chan;
    logic       evt_ok;
    logic [1:0] corr_count;
    logic [1:0] fail_count;

    int         checks   = 0;
    int         failures = 0;
    int         cur;
    logic [3:0] stuck;
    logic [3:0] pulse_val;
    int         pulse_cyc;
    int         pulse_cnt;

    logic [1:0] ch;
    logic       ok;
    int         at;

    always #5 clk = ~clk;

    correction_sequencer #(
        .N_CHAN         (4),
        .DECODE_LAT     (3),
        .VERIFY_TIMEOUT (4),
        .CNT_W          (2)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable             (enable),
        .error_state_i      (error_state),
        .apply_correction_o (apply_correction),
        .busy_o             (busy),
        .active_chan_o      (active_chan),
        .evt_valid_o        (evt_valid),
        .evt_ready_i        (evt_ready),
        .evt_chan_o         (evt_chan),
        .evt_ok_o           (evt_ok),
        .corr_count_o       (corr_count),
        .fail_count_o       (fail_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cur);
        end
    endtask

    // Advance one cycle; channels that saw a pulse clear unless stuck
    task automatic tick();
        logic [3:0] p;
        p = apply_correction;
        if (p != 4'b0) begin
            pulse_cnt++;
            pulse_cyc = cur;
            pulse_val = p;
        end
        @(posedge clk);
        #1;
        cur++;
        error_state = error_state & ~(p & ~stuck);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        enable      = 1'b0;
        evt_ready   = 1'b1;
        error_state = 4'b0;
        stuck       = 4'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        cur       = 0;
        pulse_cnt = 0;
        pulse_cyc = -1;
        pulse_val = 4'b0;
    endtask

    task automatic wait_evt(output logic [1:0] c, output logic o, output int t);
        int n;
        n = 0;
        while (!evt_valid && n < 60) begin
            tick();
            n++;
        end
        check("evt_seen", int'(evt_valid), 1);
        c = evt_chan;
        o = evt_ok;
        t = cur;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int rr_exp[3];
        int st_ch[4];
        int st_ok[4];
        int n;
        rr_exp = '{0, 1, 3};
        st_ch  = '{0, 1, 3, 1};
        st_ok  = '{1, 0, 1, 0};

        do_reset();
        check("rst_busy", int'(busy), 0);
        check("rst_apply", int'(apply_correction), 0);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_chan", int'(evt_chan), 0);
        check("rst_ok", int'(evt_ok), 0);
        check("rst_corr", int'(corr_count), 0);
        check("rst_fail", int'(fail_count), 0);

        // Single error on channel 2
        enable      = 1'b1;
        error_state = 4'b0100;
        tick();
        check("single_busy", int'(busy), 1);
        check("single_active", int'(active_chan), 2);
        wait_evt(ch, ok, at);
        check("single_evt_cycle", at, 6);
        check("single_pulse_cycle", pulse_cyc, 4);
        check("single_pulse_val", int'(pulse_val), 4);
        check("single_pulse_cnt", pulse_cnt, 1);
        check("single_chan", int'(ch), 2);
        check("single_ok", int'(ok), 1);
        check("single_corr_pre", int'(corr_count), 0);
        tick();
        check("single_corr", int'(corr_count), 1);
        check("single_idle", int'(busy), 0);
        check("single_valid_low", int'(evt_valid), 0);
        check("single_seq_len", cur, 7);

        // Round-robin over 1011
        do_reset();
        enable      = 1'b1;
        error_state = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            wait_evt(ch, ok, at);
            check("rr_chan", int'(ch), rr_exp[k]);
            check("rr_ok", int'(ok), 1);
            tick();
        end
        check("rr_corr", int'(corr_count), 3);
        check("rr_fail", int'(fail_count), 0);

        // Channel 1 ignores its pulse
        do_reset();
        enable      = 1'b1;
        stuck       = 4'b0010;
        error_state = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            wait_evt(ch, ok, at);
            check("stuck_chan", int'(ch), st_ch[k]);
            check("stuck_ok", int'(ok), st_ok[k]);
            check("stuck_verify_span", at - pulse_cyc, (st_ok[k] != 0) ? 2 : 5);
            tick();
            if (k == 1) check("stuck_fail1", int'(fail_count), 1);
        end
        check("stuck_fail2", int'(fail_count), 2);
        check("stuck_corr", int'(corr_count), 2);

        // Host backpressure
        do_reset();
        enable      = 1'b1;
        evt_ready   = 1'b0;
        error_state = 4'b0001;
        wait_evt(ch, ok, at);
        error_state = error_state | 4'b0100;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_valid", int'(evt_valid), 1);
            check("bp_chan", int'(evt_chan), 0);
            check("bp_ok", int'(evt_ok), 1);
            check("bp_corr", int'(corr_count), 0);
            check("bp_active", int'(active_chan), 0);
        end
        evt_ready = 1'b1;
        tick();
        check("bp_corr_after", int'(corr_count), 1);
        check("bp_valid_after", int'(evt_valid), 0);
        tick();
        check("bp_next_grant", int'(active_chan), 2);
        check("bp_next_busy", int'(busy), 1);

        // Enable drops during DECODE
        do_reset();
        enable      = 1'b1;
        error_state = 4'b0101;
        tick();
        enable = 1'b0;
        check("en_decode_busy", int'(busy), 1);
        wait_evt(ch, ok, at);
        check("en_chan", int'(ch), 0);
        check("en_ok", int'(ok), 1);
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            check("en_no_grant", int'(busy), 0);
        end
        check("en_corr", int'(corr_count), 1);

        // Reset asserted during APPLY
        do_reset();
        enable      = 1'b1;
        error_state = 4'b0011;
        wait_evt(ch, ok, at);
        tick();
        check("rst_pre_corr", int'(corr_count), 1);
        n = 0;
        while (apply_correction == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        check("rst_apply_seen", int'(apply_correction), 2);
        rst_n = 1'b0;
        #1;
        check("rst_apply_drop", int'(apply_correction), 0);
        check("rst_busy_drop", int'(busy), 0);
        check("rst_valid_drop", int'(evt_valid), 0);
        check("rst_corr_clear", int'(corr_count), 0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        error_state = 4'b1001;
        tick();
        check("rst_regrant", int'(active_chan), 0);
        check("rst_regrant_busy", int'(busy), 1);

        // Counter saturation at CNT_W=2
        do_reset();
        enable      = 1'b1;
        error_state = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) error_state = 4'b0001;
            wait_evt(ch, ok, at);
            check("sat_chan", int'(ch), k % 4);
            check("sat_ok", int'(ok), 1);
            tick();
            if (k == 2) check("sat_corr3", int'(corr_count), 3);
        end
        check("sat_corr_hold", int'(corr_count), 3);
        check("sat_fail", int'(fail_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
